display_request_scheduler: RTL and testbench

Sequencing controller that sits in front of the priority-encoder / 7-segment display path. It captures rising edges on eight request lines into a sticky pending register and grants one requester at a time. Each grant is held on the display for a programmable dwell time, then the pending bit is retired. Requesters are selected by fixed priority (highest index wins) or by rotating round-robin priority, and the granted index drives the 7-segment pattern and the no-data flag.

---
 rtl/display_request_scheduler.sv | 133 +++++++++++++
 tb/tb_display_request_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_request_scheduler.sv
// Captures rising edges on eight request lines into a sticky pending register
// and shows one granted index at a time on a 7-segment digit for DWELL cycles.
module display_request_scheduler #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] pending,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       done,
  output logic [6:0] segments,
  output logic       no_data
);

  generate
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("display_request_scheduler: DWELL must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [7:0] req_q;
  logic       armed;
  logic [2:0] ptr;
  logic [7:0] cnt;

  logic [7:0] rise;
  logic [7:0] clear;
  logic [2:0] fixed_idx;
  logic [2:0] rr_idx;
  logic       rr_found;
  logic [2:0] winner;
  logic       start;

  function automatic logic [6:0] seg7(input logic [2:0] d);
    case (d)
      3'd0:    seg7 = 7'h3F;
      3'd1:    seg7 = 7'h06;
      3'd2:    seg7 = 7'h5B;
      3'd3:    seg7 = 7'h4F;
      3'd4:    seg7 = 7'h66;
      3'd5:    seg7 = 7'h6D;
      3'd6:    seg7 = 7'h7D;
      default: seg7 = 7'h07;
    endcase
  endfunction

  // Ascending scan: the last (highest) set index overwrites earlier ones.
  always_comb begin
    fixed_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) fixed_idx = 3'(i);
    end
  end

  // Round-robin scan starts at ptr and descends, wrapping 0 -> 7.
  always_comb begin
    rr_idx   = ptr;
    rr_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!rr_found && pending[3'(ptr - 3'(i))]) begin
        rr_idx   = 3'(ptr - 3'(i));
        rr_found = 1'b1;
      end
    end
  end

  // armed is low only until the first edge after reset, so a req held high
  // across reset release is absorbed into req_q instead of posting a request.
  always_comb begin
    winner = mode ? rr_idx : fixed_idx;
    start  = (state == IDLE) && ena && (pending != 8'd0);
    clear  = start ? (8'b1 << winner) : 8'd0;
    rise   = armed ? (req & ~req_q) : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 8'd0;
      armed       <= 1'b0;
      pending     <= 8'd0;
      ptr         <= 3'd7;
      cnt         <= 8'd0;
      grant_valid <= 1'b0;
      grant_idx   <= 3'd0;
      done        <= 1'b0;
      segments    <= 7'h40;
      no_data     <= 1'b1;
    end else begin
      req_q   <= req;
      armed   <= 1'b1;
      pending <= (pending & ~clear) | rise;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_idx   <= winner;
            cnt         <= DWELL_M1;
            done        <= (DWELL == 1);
            segments    <= seg7(winner);
            no_data     <= 1'b0;
            ptr         <= winner - 3'd1;
          end
        end
        GRANT: begin
          if (cnt == 8'd0) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_idx   <= 3'd0;
            done        <= 1'b0;
            segments    <= 7'h40;
            no_data     <= 1'b1;
          end else begin
            cnt  <= cnt - 8'd1;
            done <= (cnt == 8'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_request_scheduler.sv
// Bench for display_request_scheduler: a grant monitor pops expected indices
// from a queue, plus a vector table and hand-written multi-cycle sequences.
module tb_display_request_scheduler;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] req;
  logic       mode;
  logic [7:0] pending;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       done;
  logic [6:0] segments;
  logic       no_data;

  display_request_scheduler #(.DWELL(DWELL)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .req         (req),
    .mode        (mode),
    .pending     (pending),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .done        (done),
    .segments    (segments),
    .no_data     (no_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        mode;
    logic [7:0]  pat;
    int          n;
    logic [31:0] seq;
  } vec_t;

  logic [6:0] seg_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  logic prev_gv = 1'b0;
  logic gstart = 1'b0;
  int dcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic monitor();
    logic [2:0] e;
    gstart = 1'b0;
    if (!mon_en) begin
      prev_gv = 1'b0;
      dcnt = 0;
      return;
    end
    if (grant_valid && !prev_gv) begin
      gstart = 1'b1;
      dcnt = 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got index %0d expected no grant at %0t", grant_idx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("grant_idx", 32'(grant_idx), 32'(e));
        chk("grant_segments", 32'(segments), 32'(seg_tab[e]));
        chk("grant_no_data", 32'(no_data), 32'd0);
      end
    end else if (grant_valid) begin
      dcnt++;
    end
    chk("done_pulse", 32'(done), 32'(grant_valid && dcnt == DWELL));
    if (!grant_valid && prev_gv) begin
      chk("dwell_length", 32'(dcnt), 32'(DWELL));
      chk("idle_segments", 32'(segments), 32'h40);
      chk("idle_no_data", 32'(no_data), 32'd1);
      chk("idle_grant_idx", 32'(grant_idx), 32'd0);
    end
    prev_gv = grant_valid;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic pulse(input logic [7:0] pat);
    req = pat;
    step();
    req = 8'd0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || grant_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!gstart && n < budget);
    chk("wait_start_timeout", 32'(gstart), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant_idx"}, 32'(grant_idx), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_segments"}, 32'(segments), 32'h40);
    chk({tag, "_no_data"}, 32'(no_data), 32'd1);
  endtask

  vec_t vecs [7];

  initial begin
    // Expected sequences are read left to right, one hex digit per grant.
    vecs[0] = '{mode: 1'b0, pat: 8'hA4, n: 3, seq: 32'h752};
    vecs[1] = '{mode: 1'b0, pat: 8'h81, n: 2, seq: 32'h70};
    vecs[2] = '{mode: 1'b1, pat: 8'h0F, n: 4, seq: 32'h3210};
    vecs[3] = '{mode: 1'b1, pat: 8'h90, n: 2, seq: 32'h74};
    vecs[4] = '{mode: 1'b1, pat: 8'h22, n: 2, seq: 32'h15};
    vecs[5] = '{mode: 1'b1, pat: 8'hFF, n: 8, seq: 32'h43210765};
    vecs[6] = '{mode: 1'b0, pat: 8'h18, n: 2, seq: 32'h43};

    rst = 1'b1;
    ena = 1'b0;
    req = 8'd0;
    mode = 1'b0;
    #1;
    check_reset("por");
    repeat (2) step();
    check_reset("reset_held");
    rst = 1'b0;
    ena = 1'b1;
    mon_en = 1'b1;
    step();

    // Single request on index 5.
    exp_q.push_back(3'd5);
    req = 8'h20;
    step();
    chk("single_pending_set", 32'(pending), 32'h20);
    chk("single_not_yet_granted", 32'(grant_valid), 32'd0);
    req = 8'd0;
    drain(40);
    chk("single_pending_cleared", 32'(pending), 32'd0);

    // Vector table: one burst of requests, then the expected grant order.
    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].mode;
      for (int k = 0; k < vecs[v].n; k++)
        exp_q.push_back(vecs[v].seq[4*(vecs[v].n-1-k) +: 3]);
      pulse(vecs[v].pat);
      drain(100);
      chk("vec_pending_cleared", 32'(pending), 32'd0);
    end

    // Round-robin with 7 and 6 re-posted during each of the first three grants.
    mode = 1'b1;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd7);
    pulse(8'hC0);
    for (int r = 0; r < 3; r++) begin
      wait_start(20);
      pulse(8'hC0);
    end
    drain(80);
    chk("rr_pending_cleared", 32'(pending), 32'd0);

    // Re-post of index 3 on the very edge where index 3 is granted.
    mode = 1'b0;
    ena = 1'b0;
    pulse(8'h08);
    step();
    chk("repost_pending_before", 32'(pending), 32'h08);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    ena = 1'b1;
    req = 8'h08;
    step();
    req = 8'd0;
    chk("repost_grant_started", 32'(grant_valid), 32'd1);
    chk("repost_set_wins", 32'(pending), 32'h08);
    drain(40);
    chk("repost_pending_cleared", 32'(pending), 32'd0);

    // ena gating, including ena dropping in the middle of a grant.
    ena = 1'b0;
    pulse(8'h81);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("gate_no_data", 32'(no_data), 32'd1);
      chk("gate_pending", 32'(pending), 32'h81);
    end
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    ena = 1'b1;
    wait_start(10);
    step();
    ena = 1'b0;
    begin
      int n = 0;
      while (grant_valid && n < 20) begin
        step();
        n++;
      end
      chk("gate_grant_finish_timeout", 32'(grant_valid), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gate_blocked_valid", 32'(grant_valid), 32'd0);
      chk("gate_blocked_pending", 32'(pending), 32'h01);
    end
    ena = 1'b1;
    drain(40);
    chk("gate_pending_cleared", 32'(pending), 32'd0);

    // Asynchronous reset during the second cycle of a grant.
    mon_en = 1'b0;
    pulse(8'h10);
    begin
      int n = 0;
      while (!grant_valid && n < 20) begin
        step();
        n++;
      end
      chk("rst_wait_grant", 32'(grant_valid), 32'd1);
    end
    step();
    chk("rst_mid_grant_active", 32'(no_data), 32'd0);
    #2;
    rst = 1'b1;
    req = 8'hFF;
    #1;
    check_reset("async_rst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("held_req_no_grant", 32'(grant_valid), 32'd0);
      chk("held_req_no_pending", 32'(pending), 32'd0);
    end
    req = 8'd0;
    step();
    mon_en = 1'b1;
    step();

    // First grant after reset matches fixed priority even in round-robin mode.
    mode = 1'b1;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd2);
    pulse(8'h24);
    drain(40);
    chk("final_pending_cleared", 32'(pending), 32'd0);

    // A few random bursts in fixed priority: grants follow descending index.
    mode = 1'b0;
    for (int t = 0; t < 4; t++) begin
      logic [7:0] p;
      p = 8'($urandom_range(1, 255));
      for (int i = 7; i >= 0; i--)
        if (p[i]) exp_q.push_back(3'(i));
      pulse(p);
      drain(120);
      chk("rand_pending_cleared", 32'(pending), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
